fnp_pkt_dispatch: RTL and testbench
===================================

# fnp_pkt_dispatch

Packet dispatcher directly downstream of the first-node process output FIFO (134-bit cells, show-ahead). It pops cells only when a whole packet can be accepted downstream, checks cell framing, repairs broken packets by forcing a tail, and discards orphan cells. It then forwards well-formed packets, one cell per cycle, to the output scheduling stage.

## Interface
Parameters:
- MAX_PKT_CELLS, 128, maximum cells per packet (2048 B / 16 B); counter sized to hold this value
- FREE_W, 9, width of downstream free-cell credit

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_fnp_fifo_empty  in  1  upstream FIFO empty
- iv_fnp_fifo_data  in  134  show-ahead head cell; [133:132] 01=head, 11=middle, 10=tail, 00=invalid; [131:0] passed through
- o_fnp_fifo_rd  out  1  pop upstream cell (combinational)
- iv_free_cells  in  FREE_W  downstream free cells
- ov_pkt_data  out  134  output cell (registered)
- o_pkt_data_wr  out  1  output cell valid (registered)
- o_pkt_out_pulse  out  1  one cycle per emitted tail, including forced tails
- o_pkt_trunc_pulse  out  1  one cycle per forced tail
- o_drop_cell_pulse  out  1  one cycle per discarded cell

## Operation
- Hold register (hold_data) keeps the last popped cell of the current packet. It is emitted when the next cell's type is known, which allows retagging it as a tail.
- cnt counts the cells of the current packet, including the held cell.
- The pop condition is evaluated only when i_fnp_fifo_empty=0; while empty, the block waits and keeps all state.
- IDLE:
  - Head cell and iv_free_cells >= MAX_PKT_CELLS: pop, hold it, cnt=1, go to SEND.
  - Head cell with insufficient credit: no pop; wait.
  - Non-head cell: pop, pulse drop, stay in IDLE.
- SEND, by incoming cell type:
  - cnt==MAX_PKT_CELLS and incoming cell is not a tail: no pop; emit hold with [133:132] forced to 10; pulse trunc and out; go to DISCARD.
  - Middle: pop, emit hold, hold=cell, cnt+1.
  - Tail: pop, emit hold, hold=cell, go to FLUSH.
  - Head (tail missing): no pop; emit hold forced to 10; pulse trunc and out; go to IDLE. The head is then handled by the IDLE rules.
  - Invalid (00): pop, discard, pulse drop; hold and cnt unchanged.
- FLUSH: emit hold (the tail) unconditionally, pulse out, go to IDLE. Nothing is popped in this state.
- DISCARD:
  - Tail: pop, pulse drop, go to IDLE.
  - Head: no pop, go to IDLE.
  - Other: pop, pulse drop.
- Credit is checked only at the head. Downstream guarantees iv_free_cells does not shrink below the reserved amount during the packet.
- Emitted bits [131:0] always equal the popped cell unchanged.

## Timing
- Reset (asynchronous): state IDLE; hold cleared; cnt=0; ov_pkt_data=0; o_pkt_data_wr=0; all pulses 0. o_fnp_fifo_rd=0 while rst_n=0.
- Reset asserted mid-packet abandons the packet with no forced tail. After release, upstream cells are handled by the IDLE rules.
- o_fnp_fifo_rd is combinational from state, empty, cell type, cnt and credit. The FIFO pops on the same edge.
- A cell popped at edge N is emitted when the next decision fires at edge M: ov_pkt_data and o_pkt_data_wr are valid in the cycle after M.
  - Unbroken N-cell packet with a continuously non-empty FIFO: head popped at cycle t, output cells in cycles t+2 … t+N+1, tail emitted from FLUSH.
  - Next head can pop at t+N+1; the FLUSH state costs one bubble cycle.
- Pulses are registered and aligned with the o_pkt_data_wr cycle of the related cell, or with the pop cycle for drops.
- Throughput: 1 cell/cycle within a packet; at most one emit and one pop per cycle.

## Test plan
- MAX_PKT_CELLS=8, credit 511; push 4-cell packet 01,11,11,10 → 4 output cells, tags identical and in order, one out pulse coincident with the tail, zero trunc/drop pulses, first output 2 cycles after the first pop.
- Credit 7 with MAX=8, head waiting → no pop, no output; raise credit to 8 → head popped the next evaluated cycle, packet forwarded.
- Sequence 01,11,01,11,10 → first packet emitted as 01,10 (retagged), trunc=1 once; second packet 01,11,10 intact; out pulses=2.
- 12 cells 01,11×10,10 with MAX=8 → 8 cells out, the 8th tagged 10, trunc=1; remaining 4 cells dropped (4 drop pulses); IDLE afterward.
- Orphans 11,10,00 in IDLE, then valid packet → 3 drop pulses, packet forwarded intact.
- Assert rst_n low on the 3rd output cycle of a 6-cell packet → outputs 0 immediately; after release, remaining 11/10 cells dropped until the next head.

Source files
------------

// File: rtl/fnp_pkt_dispatch.sv
// Packet dispatcher after the first-node FIFO: pops whole packets only with enough
// downstream credit, repairs missing tails, drops orphan cells, emits one cell per cycle.
module fnp_pkt_dispatch #(
  parameter int MAX_PKT_CELLS = 128,
  parameter int FREE_W        = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fnp_fifo_empty,
  input  logic [133:0]      iv_fnp_fifo_data,
  output logic              o_fnp_fifo_rd,
  input  logic [FREE_W-1:0] iv_free_cells,
  output logic [133:0]      ov_pkt_data,
  output logic              o_pkt_data_wr,
  output logic              o_pkt_out_pulse,
  output logic              o_pkt_trunc_pulse,
  output logic              o_drop_cell_pulse
);

  // state   | meaning
  // IDLE    | waiting for a head cell with enough credit; orphans dropped
  // SEND    | packet in flight, last popped cell in hold_data
  // FLUSH   | emit the held tail, no pop
  // DISCARD | dropping the rest of an over-length packet up to its tail
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_FLUSH   = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam int          CNT_W  = $clog2(MAX_PKT_CELLS + 1);
  localparam logic [1:0]  T_HEAD = 2'b01;
  localparam logic [1:0]  T_MID  = 2'b11;
  localparam logic [1:0]  T_TAIL = 2'b10;
  localparam logic [1:0]  T_INV  = 2'b00;
  localparam logic [31:0] MAX_U  = 32'(MAX_PKT_CELLS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_CELLS);

  state_t           state;
  logic [133:0]     hold_data;
  logic [CNT_W-1:0] cnt;

  logic [1:0] cell_type;
  logic       credit_ok;
  logic       at_max;

  assign cell_type = iv_fnp_fifo_data[133:132];
  assign credit_ok = (32'(iv_free_cells) >= MAX_U);
  assign at_max    = (cnt == CNT_MAX);

  always_comb begin
    o_fnp_fifo_rd = 1'b0;
    if (rst_n && !i_fnp_fifo_empty) begin
      case (state)
        S_IDLE:    o_fnp_fifo_rd = (cell_type != T_HEAD) || credit_ok;
        S_SEND: begin
          if (at_max && (cell_type != T_TAIL))
            o_fnp_fifo_rd = 1'b0;
          else
            o_fnp_fifo_rd = (cell_type != T_HEAD);
        end
        S_FLUSH:   o_fnp_fifo_rd = 1'b0;
        S_DISCARD: o_fnp_fifo_rd = (cell_type != T_HEAD);
        default:   o_fnp_fifo_rd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      hold_data         <= '0;
      cnt               <= '0;
      ov_pkt_data       <= '0;
      o_pkt_data_wr     <= 1'b0;
      o_pkt_out_pulse   <= 1'b0;
      o_pkt_trunc_pulse <= 1'b0;
      o_drop_cell_pulse <= 1'b0;
    end else begin
      o_pkt_data_wr     <= 1'b0;
      o_pkt_out_pulse   <= 1'b0;
      o_pkt_trunc_pulse <= 1'b0;
      o_drop_cell_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!i_fnp_fifo_empty) begin
            if (cell_type == T_HEAD) begin
              if (credit_ok) begin
                hold_data <= iv_fnp_fifo_data;
                cnt       <= CNT_W'(1);
                state     <= S_SEND;
              end
            end else begin
              o_drop_cell_pulse <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (!i_fnp_fifo_empty) begin
            // Packet already at the size limit: close it on the held cell.
            if (at_max && (cell_type != T_TAIL)) begin
              ov_pkt_data       <= {T_TAIL, hold_data[131:0]};
              o_pkt_data_wr     <= 1'b1;
              o_pkt_trunc_pulse <= 1'b1;
              o_pkt_out_pulse   <= 1'b1;
              cnt               <= '0;
              state             <= S_DISCARD;
            end else begin
              case (cell_type)
                T_MID: begin
                  ov_pkt_data   <= hold_data;
                  o_pkt_data_wr <= 1'b1;
                  hold_data     <= iv_fnp_fifo_data;
                  cnt           <= cnt + CNT_W'(1);
                end
                T_TAIL: begin
                  ov_pkt_data   <= hold_data;
                  o_pkt_data_wr <= 1'b1;
                  hold_data     <= iv_fnp_fifo_data;
                  cnt           <= cnt + CNT_W'(1);
                  state         <= S_FLUSH;
                end
                T_HEAD: begin
                  // Tail missing: retag the held cell, leave the head for IDLE.
                  ov_pkt_data       <= {T_TAIL, hold_data[131:0]};
                  o_pkt_data_wr     <= 1'b1;
                  o_pkt_trunc_pulse <= 1'b1;
                  o_pkt_out_pulse   <= 1'b1;
                  cnt               <= '0;
                  state             <= S_IDLE;
                end
                default: begin
                  o_drop_cell_pulse <= 1'b1;
                end
              endcase
            end
          end
        end
        S_FLUSH: begin
          ov_pkt_data     <= hold_data;
          o_pkt_data_wr   <= 1'b1;
          o_pkt_out_pulse <= 1'b1;
          cnt             <= '0;
          state           <= S_IDLE;
        end
        S_DISCARD: begin
          if (!i_fnp_fifo_empty) begin
            if (cell_type == T_HEAD) begin
              state <= S_IDLE;
            end else begin
              o_drop_cell_pulse <= 1'b1;
              if (cell_type == T_TAIL)
                state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_inv;
  assign unused_inv = (T_INV == 2'b00);

endmodule

// File: tb/tb_fnp_pkt_dispatch.sv
// Self-checking bench for fnp_pkt_dispatch: FIFO model feeds the DUT, a scoreboard
// queue of expected output cells is checked as cells are emitted.
module tb_fnp_pkt_dispatch;

  localparam int MAX = 8;
  localparam int FW  = 9;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [133:0]  fifo_data;
  logic          fifo_rd;
  logic [FW-1:0] free_cells;
  logic [133:0]  pkt_data;
  logic          pkt_wr;
  logic          out_pulse;
  logic          trunc_pulse;
  logic          drop_pulse;

  fnp_pkt_dispatch #(.MAX_PKT_CELLS(MAX), .FREE_W(FW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_fnp_fifo_empty  (fifo_empty),
    .iv_fnp_fifo_data  (fifo_data),
    .o_fnp_fifo_rd     (fifo_rd),
    .iv_free_cells     (free_cells),
    .ov_pkt_data       (pkt_data),
    .o_pkt_data_wr     (pkt_wr),
    .o_pkt_out_pulse   (out_pulse),
    .o_pkt_trunc_pulse (trunc_pulse),
    .o_drop_cell_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [133:0] fq[$];
  logic [133:0] exp_q[$];
  int pend = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int n_pop, n_wr, n_out, n_out_tail, n_trunc, n_drop;
  int first_pop, first_wr;

  function automatic logic [133:0] mk(input logic [1:0] tag);
    return {tag, 4'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [133:0] retag(input logic [133:0] c);
    return {2'b10, c[131:0]};
  endfunction

  // Pops are recorded at the active edge and applied to the FIFO model at the falling edge.
  always @(posedge clk) begin
    if (fifo_rd) begin
      total++;
      if (fifo_empty) begin
        bad++;
        $display("FAIL pop_on_empty: rd=1 while empty=%0b, required no pop", fifo_empty);
      end
      pend++;
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [133:0] e;
    while (pend > 0) begin
      if (fq.size() > 0) void'(fq.pop_front());
      pend--;
    end
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? '0 : fq[0];
    if (rst_n) begin
      if (pkt_wr) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cell: got %h, required no output", pkt_data);
        end else begin
          e = exp_q.pop_front();
          if (pkt_data !== e) begin
            bad++;
            $display("FAIL cell_data: got %h, required %h", pkt_data, e);
          end
        end
        if (out_pulse && pkt_data[133:132] == 2'b10) n_out_tail++;
      end
      if (out_pulse)   n_out++;
      if (trunc_pulse) n_trunc++;
      if (drop_pulse)  n_drop++;
    end
  end

  task automatic clear_counts();
    n_pop = 0; n_wr = 0; n_out = 0; n_out_tail = 0; n_trunc = 0; n_drop = 0;
    first_pop = -1; first_wr = -1;
  endtask

  task automatic drain(input string nm);
    int idle = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (fifo_empty && pend == 0 && !pkt_wr) idle++;
      else idle = 0;
      if (idle >= 4) return;
    end
    total++; bad++;
    $display("FAIL %s_drain: fifo still holds %0d cells, required empty", nm, fq.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    free_cells = 9'd511;
    clear_counts();
    fq.push_back(mk(2'b01));
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (pkt_wr !== 1'b0 || pkt_data !== '0) begin
      bad++; $display("FAIL reset_out: wr=%b data=%h, required 0/0", pkt_wr, pkt_data);
    end
    total++;
    if ({out_pulse, trunc_pulse, drop_pulse} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses: got %b, required 000", {out_pulse, trunc_pulse, drop_pulse});
    end
    total++;
    if (fifo_rd !== 1'b0) begin
      bad++; $display("FAIL reset_rd: got %b with head present, required 0", fifo_rd);
    end
    fq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [133:0] c;
    logic [1:0] tags [4] = '{2'b01, 2'b11, 2'b11, 2'b10};
    clear_counts();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      c = mk(tags[i]);
      fq.push_back(c);
      exp_q.push_back(c);
    end
    drain("basic");
    total++;
    if (n_wr !== 4 || exp_q.size() !== 0) begin
      bad++; $display("FAIL basic_count: got %0d cells (%0d pending), required 4", n_wr, exp_q.size());
    end
    total++;
    if (first_wr - first_pop !== 2) begin
      bad++; $display("FAIL basic_latency: got %0d cycles, required 2", first_wr - first_pop);
    end
    total++;
    if (n_out !== 1 || n_out_tail !== 1 || n_trunc !== 0 || n_drop !== 0) begin
      bad++; $display("FAIL basic_pulses: out=%0d on_tail=%0d trunc=%0d drop=%0d, required 1/1/0/0",
                      n_out, n_out_tail, n_trunc, n_drop);
    end
  endtask

  task automatic test_credit();
    logic [133:0] c;
    logic [1:0] tags [4] = '{2'b01, 2'b11, 2'b11, 2'b10};
    int c_raise;
    clear_counts();
    @(negedge clk);
    free_cells = 9'd7;
    for (int i = 0; i < 4; i++) begin
      c = mk(tags[i]);
      fq.push_back(c);
      exp_q.push_back(c);
    end
    repeat (10) @(negedge clk);
    total++;
    if (n_pop !== 0 || n_wr !== 0) begin
      bad++; $display("FAIL credit_block: pops=%0d cells=%0d, required 0/0", n_pop, n_wr);
    end
    @(negedge clk);
    free_cells = 9'd8;
    c_raise = cyc;
    drain("credit");
    total++;
    if (first_pop !== c_raise) begin
      bad++; $display("FAIL credit_pop_time: popped cycle %0d, required %0d", first_pop, c_raise);
    end
    total++;
    if (n_wr !== 4 || exp_q.size() !== 0) begin
      bad++; $display("FAIL credit_count: got %0d cells, required 4", n_wr);
    end
    free_cells = 9'd511;
  endtask

  task automatic test_missing_tail();
    logic [133:0] c;
    logic [1:0] tags [5] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
    clear_counts();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      c = mk(tags[i]);
      fq.push_back(c);
      exp_q.push_back(i == 1 ? retag(c) : c);
    end
    drain("missing_tail");
    total++;
    if (n_wr !== 5 || exp_q.size() !== 0) begin
      bad++; $display("FAIL missing_tail_count: got %0d cells, required 5", n_wr);
    end
    total++;
    if (n_trunc !== 1 || n_out !== 2 || n_out_tail !== 2 || n_drop !== 0) begin
      bad++; $display("FAIL missing_tail_pulses: trunc=%0d out=%0d on_tail=%0d drop=%0d, required 1/2/2/0",
                      n_trunc, n_out, n_out_tail, n_drop);
    end
  endtask

  task automatic test_overlength();
    logic [133:0] c;
    clear_counts();
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      c = mk(i == 0 ? 2'b01 : (i == 11 ? 2'b10 : 2'b11));
      fq.push_back(c);
      if (i < MAX - 1)       exp_q.push_back(c);
      else if (i == MAX - 1) exp_q.push_back(retag(c));
    end
    c = mk(2'b01); fq.push_back(c); exp_q.push_back(c);
    c = mk(2'b10); fq.push_back(c); exp_q.push_back(c);
    drain("overlength");
    total++;
    if (n_wr !== MAX + 2 || exp_q.size() !== 0) begin
      bad++; $display("FAIL overlength_count: got %0d cells, required %0d", n_wr, MAX + 2);
    end
    total++;
    if (n_trunc !== 1 || n_drop !== 4 || n_out !== 2) begin
      bad++; $display("FAIL overlength_pulses: trunc=%0d drop=%0d out=%0d, required 1/4/2",
                      n_trunc, n_drop, n_out);
    end
  endtask

  task automatic test_orphans();
    logic [133:0] c;
    clear_counts();
    @(negedge clk);
    fq.push_back(mk(2'b11));
    fq.push_back(mk(2'b10));
    fq.push_back(mk(2'b00));
    c = mk(2'b01); fq.push_back(c); exp_q.push_back(c);
    c = mk(2'b11); fq.push_back(c); exp_q.push_back(c);
    c = mk(2'b10); fq.push_back(c); exp_q.push_back(c);
    drain("orphans");
    total++;
    if (n_drop !== 3 || n_trunc !== 0 || n_out !== 1) begin
      bad++; $display("FAIL orphan_pulses: drop=%0d trunc=%0d out=%0d, required 3/0/1", n_drop, n_trunc, n_out);
    end
    total++;
    if (n_wr !== 3 || exp_q.size() !== 0) begin
      bad++; $display("FAIL orphan_count: got %0d cells, required 3", n_wr);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [133:0] c;
    bit hit = 0;
    clear_counts();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      c = mk(i == 0 ? 2'b01 : (i == 5 ? 2'b10 : 2'b11));
      fq.push_back(c);
      if (i < 3) exp_q.push_back(c);
    end
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk); #1;
      if (n_wr == 3) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL rst_mid_wait: got %0d cells, required 3", n_wr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (pkt_wr !== 1'b0 || pkt_data !== '0 || fifo_rd !== 1'b0) begin
      bad++; $display("FAIL rst_mid_out: wr=%b data=%h rd=%b, required 0/0/0", pkt_wr, pkt_data, fifo_rd);
    end
    repeat (2) @(negedge clk);
    clear_counts();
    rst_n = 1'b1;
    c = mk(2'b01); fq.push_back(c); exp_q.push_back(c);
    c = mk(2'b10); fq.push_back(c); exp_q.push_back(c);
    drain("rst_mid");
    total++;
    if (n_drop !== 2 || n_trunc !== 0 || n_out !== 1) begin
      bad++; $display("FAIL rst_mid_pulses: drop=%0d trunc=%0d out=%0d, required 2/0/1", n_drop, n_trunc, n_out);
    end
    total++;
    if (n_wr !== 2 || exp_q.size() !== 0) begin
      bad++; $display("FAIL rst_mid_count: got %0d cells, required 2", n_wr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    free_cells = 9'd511;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    clear_counts();
    test_reset();
    test_basic();
    test_credit();
    test_missing_tail();
    test_overlength();
    test_orphans();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
